// File: rtl/tdp_ram_pkg.sv
// Shared constants and helpers for the true-dual-port RAM.
// Optional output stage is selected with TDP_RAM_OUTREG_EN.
package tdp_ram_pkg;

    localparam int WRM_NO_CHANGE   = 0;
    localparam int WRM_READ_FIRST  = 1;
    localparam int WRM_WRITE_FIRST = 2;

    localparam int COLL_CNT_W = 8;

    // Widest word the merge helper handles; callers extend/truncate.
    localparam int MERGE_W    = 256;
    localparam int MERGE_BE_W = MERGE_W / 8;

    function automatic logic [MERGE_W-1:0] byte_merge(
        input logic [MERGE_W-1:0]    old_w,
        input logic [MERGE_W-1:0]    new_w,
        input logic [MERGE_BE_W-1:0] be
    );
        logic [MERGE_W-1:0] res;
        res = old_w;
        for (int i = 0; i < MERGE_BE_W; i++) begin
            if (be[i]) begin
                res[8*i +: 8] = new_w[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/tdp_ram_port.sv
// Per-port request decode, read-during-write mux and rvalid strobe.
// TDP_RAM_OUTREG_EN adds a second output register stage.
module tdp_ram_port
    import tdp_ram_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int WR_MODE = WRM_NO_CHANGE
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              we,
    input  logic [DATA_W-1:0] old_word,
    input  logic [DATA_W-1:0] final_word,
    output logic [DATA_W-1:0] q,
    output logic              rvalid
);

    logic [DATA_W-1:0] q_d;
    logic [DATA_W-1:0] q_q;
    logic              rv_d;
    logic              rv_q;

    always_comb begin
        q_d  = q_q;
        rv_d = 1'b0;
        if (en && !we) begin
            q_d  = old_word;
            rv_d = 1'b1;
        end else if (en && we) begin
            if (WR_MODE == WRM_READ_FIRST) begin
                q_d  = old_word;
                rv_d = 1'b1;
            end else if (WR_MODE == WRM_WRITE_FIRST) begin
                q_d  = final_word;
                rv_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q  <= '0;
            rv_q <= 1'b0;
        end else begin
            q_q  <= q_d;
            rv_q <= rv_d;
        end
    end

`ifdef TDP_RAM_OUTREG_EN
    logic [DATA_W-1:0] q2_d;
    logic [DATA_W-1:0] q2_q;
    logic              rv2_d;
    logic              rv2_q;

    always_comb begin
        q2_d  = q_q;
        rv2_d = rv_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q2_q  <= '0;
            rv2_q <= 1'b0;
        end else begin
            q2_q  <= q2_d;
            rv2_q <= rv2_d;
        end
    end

    assign q      = q2_q;
    assign rvalid = rv2_q;
`else
    assign q      = q_q;
    assign rvalid = rv_q;
`endif

endmodule

// File: rtl/tdp_ram.sv
// True-dual-port synchronous RAM with byte lanes and A-wins write arbitration.
// Define TDP_RAM_OUTREG_EN for 2-cycle read latency on both ports.
module tdp_ram
    import tdp_ram_pkg::*;
#(
    parameter int  DATA_W  = 8,
    parameter int  ADDR_W  = 6,
    parameter int  WR_MODE = 0,
    localparam int BE_W    = DATA_W / 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en_a,
    input  logic                  en_b,
    input  logic                  we_a,
    input  logic                  we_b,
    input  logic [BE_W-1:0]       be_a,
    input  logic [BE_W-1:0]       be_b,
    input  logic [ADDR_W-1:0]     addr_a,
    input  logic [ADDR_W-1:0]     addr_b,
    input  logic [DATA_W-1:0]     data_a,
    input  logic [DATA_W-1:0]     data_b,
    output logic [DATA_W-1:0]     q_a,
    output logic [DATA_W-1:0]     q_b,
    output logic                  rvalid_a,
    output logic                  rvalid_b,
    output logic                  collision,
    output logic [COLL_CNT_W-1:0] coll_cnt
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0]     mem_q [DEPTH];
    logic [DATA_W-1:0]     old_a;
    logic [DATA_W-1:0]     old_b;
    logic [DATA_W-1:0]     wdata_a;
    logic [DATA_W-1:0]     wdata_b;
    logic [DATA_W-1:0]     final_a;
    logic [DATA_W-1:0]     final_b;
    logic                  wr_a;
    logic                  wr_b;
    logic                  coll_d;
    logic                  coll_q;
    logic [COLL_CNT_W-1:0] coll_cnt_d;
    logic [COLL_CNT_W-1:0] coll_cnt_q;

    always_comb begin
        old_a   = mem_q[addr_a];
        old_b   = mem_q[addr_b];
        wdata_a = DATA_W'(byte_merge(MERGE_W'(old_a), MERGE_W'(data_a),
                                     MERGE_BE_W'(be_a)));
        wdata_b = DATA_W'(byte_merge(MERGE_W'(old_b), MERGE_W'(data_b),
                                     MERGE_BE_W'(be_b)));
        coll_d  = en_a & we_a & en_b & we_b & (addr_a == addr_b);
        wr_a    = en_a & we_a & ~rst;
        wr_b    = en_b & we_b & ~rst & ~coll_d;
        // On a collision the word B sees stored is A's merged word.
        final_a = wdata_a;
        final_b = coll_d ? wdata_a : wdata_b;
        coll_cnt_d = coll_cnt_q;
        if (coll_d && (coll_cnt_q != '1)) begin
            coll_cnt_d = coll_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_a) begin
            mem_q[addr_a] <= wdata_a;
        end
        if (wr_b) begin
            mem_q[addr_b] <= wdata_b;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            coll_q     <= 1'b0;
            coll_cnt_q <= '0;
        end else begin
            coll_q     <= coll_d;
            coll_cnt_q <= coll_cnt_d;
        end
    end

    assign collision = coll_q;
    assign coll_cnt  = coll_cnt_q;

    tdp_ram_port #(
        .DATA_W  (DATA_W),
        .WR_MODE (WR_MODE)
    ) u_port_a (
        .clk        (clk),
        .rst        (rst),
        .en         (en_a),
        .we         (we_a),
        .old_word   (old_a),
        .final_word (final_a),
        .q          (q_a),
        .rvalid     (rvalid_a)
    );

    tdp_ram_port #(
        .DATA_W  (DATA_W),
        .WR_MODE (WR_MODE)
    ) u_port_b (
        .clk        (clk),
        .rst        (rst),
        .en         (en_b),
        .we         (we_b),
        .old_word   (old_b),
        .final_word (final_b),
        .q          (q_b),
        .rvalid     (rvalid_b)
    );

endmodule

// File: doc/tdp_ram.md
# tdp_ram

Parametrised true-dual-port synchronous RAM, the successor to the fixed 8x64 dual-port RAM. Two fully independent read/write ports share one array and one clock. The block adds per-port enables, byte-lane write enables, a selectable read-during-write mode, read-valid strobes, and deterministic write-collision arbitration with a collision counter. It sits wherever the design needs shared scratch storage between two masters, e.g. a producer/consumer pair or a DMA and a CPU.

## Interface
- `DATA_W`, 8: word width in bits; must be a multiple of 8.
- `ADDR_W`, 6: address width; depth = 2**ADDR_W words.
- `WR_MODE`, 0: port read-during-write behaviour. 0 = NO_CHANGE, 1 = READ_FIRST, 2 = WRITE_FIRST.
- `BE_W`, DATA_W/8: byte-enable width; derived, not overridden.

Ports:
- `clk` in 1: single clock; all logic on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `en_a`, `en_b` in 1: port access enable; no access when low.
- `we_a`, `we_b` in 1: write when high with en, read when low with en.
- `be_a`, `be_b` in BE_W: byte-lane write enables, bit i covers bits [8i+7:8i].
- `addr_a`, `addr_b` in ADDR_W: word address.
- `data_a`, `data_b` in DATA_W: write data.
- `q_a`, `q_b` out DATA_W: read data.
- `rvalid_a`, `rvalid_b` out 1: q_x carries data for an accepted access.
- `collision` out 1: one-cycle pulse, write/write collision detected.
- `coll_cnt` out 8: saturating collision count.

## Operation
- **Read** (en & !we): q_x is loaded with mem[addr_x] and rvalid_x pulses.
- **Write** (en & we): only lanes with be bit set are updated. A write with be all-zero changes no memory but still counts as a write cycle for WR_MODE.
- **Write cycle output, per WR_MODE:**
  - NO_CHANGE: q_x holds and rvalid_x = 0.
  - READ_FIRST: q_x gets the pre-write word and rvalid_x = 1.
  - WRITE_FIRST: q_x gets the final stored word, i.e. the byte-merged result after arbitration, and rvalid_x = 1.
- **Idle** (en low): q_x holds and rvalid_x = 0.
- **Cross-port read/write, same address, same cycle:** the reader always gets the old word.
- **Collision:** en_a & we_a & en_b & we_b & addr_a == addr_b.
  - Port A wins and the whole port B write is dropped. Overlapping byte lanes are not considered.
  - `collision` pulses and `coll_cnt` increments, stopping at 255.
- **Read/read** at the same address is legal with no side effects.
- **Reset:**
  - Clears q_a, q_b, rvalid_a, rvalid_b, collision and coll_cnt to 0.
  - Memory contents are not cleared.
  - Accesses presented while rst is high are ignored, including writes.
- Out-of-range addresses are impossible because depth = 2**ADDR_W.

## Timing
- Base read latency is 1 cycle: a request at edge N gives q_x/rvalid_x valid after edge N+1.
- Written data is readable by either port from the cycle after the write edge.
- `collision` asserts the cycle after the colliding request and coincides with `coll_cnt`'s new value.
- Back-to-back accesses at full rate on both ports are supported with no stalls.
- Reset asserted mid-stream drops every in-flight read: rvalid_x is 0 in the cycle after rst.

## Configuration
- `TDP_RAM_OUTREG_EN`: adds an output register stage on both ports.
  - Defined: read latency is 2 cycles, rvalid_x is delayed alongside q_x, and reset flushes both stages.
  - Undefined: 1-cycle latency as above.
- `collision`/`coll_cnt` timing is unchanged by the macro.

## Structure
- `tdp_ram_pkg` holds:
  - WR_MODE constants `WRM_NO_CHANGE`, `WRM_READ_FIRST`, `WRM_WRITE_FIRST`.
  - `COLL_CNT_W` = 8.
  - A byte-merge function (old word, new word, be) -> word.
- The array lives in the top level.
- Sub-module `tdp_ram_port` (one instance per port) implements the request decode, the WR_MODE output mux, the rvalid generation and the optional output stage.

## Test plan
- **Reset state:** rst=1 for 2 cycles with en_a=we_a=1 -> all outputs 0; a subsequent read of that address shows no write occurred.
- **Byte-lane write then read**, DATA_W=32: write 0xAABBCCDD to addr 5 via A with be_a=4'hF, then 0x11223344 with be_a=4'b0101, then read via B -> q_b=0xAA22CC44 and rvalid_b=1 exactly 1 cycle after the request (2 with the macro).
- **WR_MODE sweep:** mem[3]=0x10; write 0x20 to addr 3 on A -> q_a holds with rvalid_a=0 (mode 0), q_a=0x10 (mode 1), q_a=0x20 (mode 2).
- **Collision:** A writes 0x55 and B writes 0x66 to addr 9 in the same cycle -> mem[9]=0x55, collision pulses 1 cycle, coll_cnt=1; after 300 collisions coll_cnt=255.
- **Cross-port read during write:** mem[7]=0x01; A writes 0x02 to addr 7 while B reads addr 7 -> q_b=0x01; next-cycle B read -> 0x02.
- **Full-rate random traffic** on both ports, checked against a reference model including arbitration, with rst pulsed mid-run -> rvalid_x drops the cycle after reset and memory is preserved.
